// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit. Steps each instruction through FETCH, DECODE and a
// class-specific execute/memory/writeback sequence, driving datapath enables per state.
// Memory accesses wait on mem_ready_i with an optional timeout. Illegal opcodes and memory
// timeouts park the machine in a sticky error state. Retired instructions are counted.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-high reset
//   en_i                   run enable, sampled only in IDLE and in an instruction's last cycle
//   instr_op_i[5:0]        opcode from IR, consumed in DECODE
//   zero_i                 ALU zero flag, used by BRANCH
//   mem_ready_i            memory completes the current request
//   mem_req_o, mem_we_o    memory request / write strobe
//   i_or_d_o               memory address select (0 = PC, 1 = ALUOut)
//   ir_write_o, pc_write_o IR / PC load enables
//   pc_src_o[1:0]          PC source (00 ALU, 01 ALUOut, 10 jump target)
//   alu_src_a_o            ALU A select (0 = PC, 1 = rs)
//   alu_src_b_o[1:0]       ALU B select (00 rt, 01 const 4, 10 imm, 11 imm<<2)
//   alu_op_o[2:0]          ALU operation
//   reg_write_o, reg_dst_o, mem_to_reg_o  register file write controls
//   retire_o               pulses in an instruction's final cycle
//   err_o                  sticky error indication
//   state_o[3:0]           current state code (debug)
//   instr_cnt_o[CNT_W-1:0] retired-instruction count, wrapping
module multicycle_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TO_W        = 4,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             i_or_d_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             retire_o,
  output logic             err_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StWbR     = 4'd4,
    StExecI   = 4'd5,
    StWbI     = 4'd6,
    StMemAddr = 4'd7,
    StMemRd   = 4'd8,
    StMemWb   = 4'd9,
    StMemWr   = 4'd10,
    StBranch  = 4'd11,
    StJump    = 4'd12,
    StErr     = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // Last count value before a wait expires; unused when the timeout is disabled.
  localparam logic [TO_W-1:0] ToLimit = TO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_q == ToLimit);
  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    to_d         = '0;  // any state change or non-wait state clears the timeout count
    cnt_d        = cnt_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    retire_o     = 1'b0;
    err_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en_i) state_d = StFetch;
      end
      StFetch: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = StDecode;
        end else if (timeout_hit) begin
          state_d = StErr;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      StDecode: begin
        alu_src_b_o = 2'b11;
        op_d        = instr_op_i;
        case (instr_op_i)
          OpRtype:                       state_d = StExecR;
          OpLw, OpSw:                    state_d = StMemAddr;
          OpBeq, OpBne:                  state_d = StBranch;
          OpJ:                           state_d = StJump;
          OpAddi, OpSlti, OpOri, OpLui:  state_d = StExecI;
          default:                       state_d = StErr;
        endcase
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        state_d     = StWbR;
      end
      StWbR: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire_o    = 1'b1;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (op_q)
          OpSlti:  alu_op_o = 3'b011;
          OpOri:   alu_op_o = 3'b100;
          OpLui:   alu_op_o = 3'b101;
          default: alu_op_o = 3'b000;
        endcase
        state_d = StWbI;
      end
      StWbI: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (op_q == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) begin
          state_d = StMemWb;
        end else if (timeout_hit) begin
          state_d = StErr;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_o     = 1'b1;
      end
      StMemWr: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
        end else if (timeout_hit) begin
          state_d = StErr;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b001;
        pc_src_o    = 2'b01;
        pc_write_o  = (op_q == OpBeq) ? zero_i : ~zero_i;
        retire_o    = 1'b1;
      end
      StJump: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
        retire_o   = 1'b1;
      end
      StErr: begin
        err_o = 1'b1;
      end
      default: begin
        state_d = StErr;
      end
    endcase

    // Final cycle of any instruction: count it and pick the next fetch or idle.
    if (retire_o) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = en_i ? StFetch : StIdle;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int unsigned CntW       = 4;
  localparam int unsigned ToW        = 4;
  localparam int unsigned MemTimeout = 8;

  localparam int SIdle = 0, SFetch = 1, SDecode = 2, SExecR = 3, SWbR = 4, SExecI = 5;
  localparam int SWbI = 6, SMemAddr = 7, SMemRd = 8, SMemWb = 9, SMemWr = 10;
  localparam int SBranch = 11, SJump = 12, SErr = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [5:0]      instr_op = '0;
  logic            zero = 1'b0;
  logic            mem_ready = 1'b0;
  logic            mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0]      pc_src;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [2:0]      alu_op;
  logic            reg_write, reg_dst, mem_to_reg, retire, err;
  logic [3:0]      state;
  logic [CntW-1:0] instr_cnt;
  logic [17:0]     outs;

  multicycle_ctrl #(
    .CNT_W      (CntW),
    .TO_W       (ToW),
    .MEM_TIMEOUT(MemTimeout)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .instr_op_i  (instr_op),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .i_or_d_o    (i_or_d),
    .ir_write_o  (ir_write),
    .pc_write_o  (pc_write),
    .pc_src_o    (pc_src),
    .alu_src_a_o (alu_src_a),
    .alu_src_b_o (alu_src_b),
    .alu_op_o    (alu_op),
    .reg_write_o (reg_write),
    .reg_dst_o   (reg_dst),
    .mem_to_reg_o(mem_to_reg),
    .retire_o    (retire),
    .err_o       (err),
    .state_o     (state),
    .instr_cnt_o (instr_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_write, reg_dst, mem_to_reg, retire, err};

  int checks = 0;
  int errors = 0;
  int m_cnt = 0;      // reference retired count, modulo 2**CntW
  bit idle_next = 1;  // next instruction must first leave IDLE

  typedef struct {
    int st;
    bit rdy;
    bit dec;
    bit ret;
    bit e;
  } step_t;

  step_t q[$];

  // Expected outputs for a cycle spent in state st, built from the per-state output rules.
  function automatic logic [17:0] expect_out(int st, logic [5:0] op, bit z, bit rdy);
    logic mreq, mwe, iod, irw, pcw, srca, rw, rd, m2r, ret, er;
    logic [1:0] pcs, srcb;
    logic [2:0] aop;
    {mreq, mwe, iod, irw, pcw, srca, rw, rd, m2r, ret, er} = '0;
    pcs = 2'b00; srcb = 2'b00; aop = 3'b000;
    case (st)
      SFetch:   begin mreq = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      SDecode:  srcb = 2'b11;
      SExecR:   begin srca = 1; aop = 3'b010; end
      SWbR:     begin rw = 1; rd = 1; ret = 1; end
      SExecI: begin
        srca = 1; srcb = 2'b10;
        aop = (op == 6'h0A) ? 3'b011 : (op == 6'h0D) ? 3'b100 : (op == 6'h0F) ? 3'b101 : 3'b000;
      end
      SWbI:     begin rw = 1; ret = 1; end
      SMemAddr: begin srca = 1; srcb = 2'b10; end
      SMemRd:   begin mreq = 1; iod = 1; end
      SMemWb:   begin rw = 1; m2r = 1; ret = 1; end
      SMemWr:   begin mreq = 1; mwe = 1; iod = 1; ret = rdy; end
      SBranch: begin
        srca = 1; aop = 3'b001; pcs = 2'b01; ret = 1;
        pcw = (op == 6'h04) ? z : ~z;
      end
      SJump:    begin pcs = 2'b10; pcw = 1; ret = 1; end
      SErr:     er = 1;
      default:  ;
    endcase
    return {mreq, mwe, iod, irw, pcw, pcs, srca, srcb, aop, rw, rd, m2r, ret, er};
  endfunction

  task automatic check_now(string tag, int st, logic [5:0] op, bit z, bit rdy);
    logic [17:0] ex;
    ex = expect_out(st, op, z, rdy);
    checks += 3;
    assert (state === 4'(st)) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", tag, state, st);
    end
    assert (outs === ex) else begin
      errors++;
      $error("FAIL %s outputs (st %0d): got %b want %b", tag, st, outs, ex);
    end
    assert (instr_cnt === CntW'(m_cnt)) else begin
      errors++;
      $error("FAIL %s instr_cnt: got %0d want %0d", tag, instr_cnt, m_cnt);
    end
  endtask

  task automatic drive(bit rdy, bit z, logic [5:0] op, bit e);
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    instr_op  = op;
    en        = e;
    #1;
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add_step(int st, bit rdy, bit dec, bit ret, bit e);
    step_t s;
    s.st = st; s.rdy = rdy; s.dec = dec; s.ret = ret; s.e = e;
    q.push_back(s);
  endfunction

  // n idle cycles without ready then a ready cycle; too many waits end in ERR instead.
  function automatic bit add_wait(int st, int n, bit ret_on_ready, bit e_after);
    if (n >= int'(MemTimeout)) begin
      for (int i = 0; i < int'(MemTimeout); i++) add_step(st, 0, 0, 0, rnd_bit());
      return 1;
    end
    for (int i = 0; i < n; i++) add_step(st, 0, 0, 0, rnd_bit());
    add_step(st, 1, 0, ret_on_ready, ret_on_ready ? e_after : rnd_bit());
    return 0;
  endfunction

  // Plays one instruction: fetch waits fw, memory waits mw, zero flag z, en in last cycle.
  task automatic run_instr(logic [5:0] op, int fw, int mw, bit z, bit en_after, string tag);
    bit to_err = 0;
    bit retired = 0;
    q.delete();
    if (idle_next) add_step(SIdle, 0, 0, 0, 1);
    to_err = add_wait(SFetch, fw, 0, 0);
    if (!to_err) begin
      add_step(SDecode, 0, 1, 0, rnd_bit());
      case (op)
        6'h00: begin add_step(SExecR, 0, 0, 0, rnd_bit()); add_step(SWbR, 0, 0, 1, en_after); end
        6'h08, 6'h0A, 6'h0D, 6'h0F: begin
          add_step(SExecI, 0, 0, 0, rnd_bit());
          add_step(SWbI, 0, 0, 1, en_after);
        end
        6'h23: begin
          add_step(SMemAddr, 0, 0, 0, rnd_bit());
          to_err = add_wait(SMemRd, mw, 0, 0);
          if (!to_err) add_step(SMemWb, 0, 0, 1, en_after);
        end
        6'h2B: begin
          add_step(SMemAddr, 0, 0, 0, rnd_bit());
          to_err = add_wait(SMemWr, mw, 1, en_after);
        end
        6'h04, 6'h05: add_step(SBranch, 0, 0, 1, en_after);
        6'h02:        add_step(SJump, 0, 0, 1, en_after);
        default:      to_err = 1;
      endcase
    end
    if (to_err) for (int i = 0; i < 3; i++) add_step(SErr, rnd_bit(), 0, 0, rnd_bit());
    foreach (q[i]) begin
      drive(q[i].rdy, z, q[i].dec ? op : 6'($urandom), q[i].e);
      check_now(tag, q[i].st, op, z, q[i].rdy);
      if (q[i].ret) begin
        m_cnt   = (m_cnt + 1) % (1 << CntW);
        retired = 1;
      end
    end
    idle_next = retired ? !en_after : 1;
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst = 1'b1;
    en  = rnd_bit();
    mem_ready = rnd_bit();
    #1;
    m_cnt = 0;
    check_now(tag, SIdle, 6'h00, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    idle_next = 1;
  endtask

  logic [5:0] legal [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0D, 6'h0F,
                             6'h23, 6'h2B};

  initial begin
    #1;
    check_now("reset", SIdle, 6'h00, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(6'h00, 0, 0, 0, 1, "add");
    run_instr(6'h23, 0, 3, 0, 1, "lw_wait3");
    run_instr(6'h23, 2, 7, 1, 1, "lw_wait7");
    run_instr(6'h04, 0, 0, 0, 1, "beq_nz");
    run_instr(6'h05, 0, 0, 0, 1, "bne_nz");
    run_instr(6'h04, 1, 0, 1, 0, "beq_z_idle");
    run_instr(6'h2B, 0, 2, 0, 1, "sw");

    for (int i = 0; i < 40; i++) begin
      run_instr(legal[$urandom_range(0, 9)], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), rnd_bit(), ($urandom_range(0, 3) != 0), "rand");
    end

    do_reset("rst_before_wrap");
    for (int i = 0; i < 16; i++) run_instr(6'h02, 0, 0, 0, (i != 15), "jump");
    drive(rnd_bit(), 0, 6'h00, 0);
    check_now("idle_after_jump", SIdle, 6'h00, 0, 0);
    checks++;
    assert (instr_cnt === '0) else begin
      errors++;
      $error("FAIL cnt_wrap: got %0d want 0", instr_cnt);
    end

    run_instr(6'h3F, 0, 0, 0, 1, "illegal");
    for (int i = 0; i < 20; i++) begin
      drive(rnd_bit(), rnd_bit(), 6'($urandom), rnd_bit());
      check_now("err_hold", SErr, 6'h3F, 0, 0);
    end
    do_reset("rst_after_err");

    run_instr(6'h2B, 0, 20, 0, 1, "sw_timeout");
    do_reset("rst_after_sw_to");
    run_instr(6'h00, 9, 0, 0, 1, "fetch_timeout");
    do_reset("rst_after_fetch_to");

    // Reset asserted between clock edges while in EXEC_I.
    drive(0, 0, 6'h00, 1);
    check_now("async_idle", SIdle, 6'h0D, 0, 0);
    drive(1, 0, 6'h00, 1);
    check_now("async_fetch", SFetch, 6'h0D, 0, 1);
    drive(0, 0, 6'h0D, 1);
    check_now("async_decode", SDecode, 6'h0D, 0, 0);
    drive(0, 0, 6'h00, 1);
    check_now("async_exec_i", SExecI, 6'h0D, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    m_cnt = 0;
    check_now("async_rst", SIdle, 6'h0D, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    idle_next = 1;

    run_instr(6'h0F, 1, 0, 0, 1, "lui_after_rst");
    run_instr(6'h0A, 0, 0, 0, 0, "slti_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
